// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_stage_reg_if : handshake/bus bundle for a pipeline stage reg |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 11,
  parameter int DATA_W = 160,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              stall;
  logic              flush;
  logic              cnt_clr;
  logic              in_ready;
  logic              out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output in_valid, in_ctrl, in_data, stall, flush, cnt_clr,
    input  in_ready, out_valid, out_ctrl, out_data,
           stall_cnt, flush_cnt, bubble_cnt
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, stall, flush, cnt_clr,
    output in_ready, out_valid, out_ctrl, out_data,
           stall_cnt, flush_cnt, bubble_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_stage_reg : stage register with stall/flush and perf counts |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pipe_stage_reg #(
  parameter int CTRL_W     = 11,
  parameter int DATA_W     = 160,
  parameter int CNT_W      = 16,
  parameter int FLUSH_DATA = 0
) (
  input  logic CLK,
  input  logic RESET,
  pipe_stage_reg_if.slave stg
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;

  assign stg.in_ready   = ~stg.stall | stg.flush;
  assign stg.out_valid  = r_valid;
  assign stg.out_ctrl   = r_ctrl;
  assign stg.out_data   = r_data;
  assign stg.stall_cnt  = r_stall_cnt;
  assign stg.flush_cnt  = r_flush_cnt;
  assign stg.bubble_cnt = r_bubble_cnt;

  // Bubbles always carry a zero control field so downstream enables stay off.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (stg.flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (FLUSH_DATA != 0)
        r_data <= '0;
    end else if (!stg.stall) begin
      r_valid <= stg.in_valid;
      r_ctrl  <= stg.in_valid ? stg.in_ctrl : '0;
      r_data  <= stg.in_data;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (stg.cnt_clr) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (stg.flush) begin
      if (!(&r_flush_cnt))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end else if (stg.stall) begin
      if (!(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end else if (!stg.in_valid) begin
      if (!(&r_bubble_cnt))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pipe_stage_reg : directed bench over three parameter sets     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_pipe_stage_reg;

  logic         CLK;
  logic         RESET;
  logic         d_valid;
  logic [31:0]  d_ctrl;
  logic [255:0] d_data;
  logic         d_stall;
  logic         d_flush;
  logic         d_clr;
  int           n_total;
  int           n_bad;

  // u0: default widths, payload held on flush
  pipe_stage_reg_if #(.CTRL_W(11), .DATA_W(160), .CNT_W(16)) if0 ();
  // u1: wide, 4-bit counters, payload zeroed on flush
  pipe_stage_reg_if #(.CTRL_W(32), .DATA_W(256), .CNT_W(4)) if1 ();
  // u2: minimal widths, 4-bit counters
  pipe_stage_reg_if #(.CTRL_W(1), .DATA_W(1), .CNT_W(4)) if2 ();

  pipe_stage_reg #(.CTRL_W(11), .DATA_W(160), .CNT_W(16), .FLUSH_DATA(0))
    u0 (.CLK(CLK), .RESET(RESET), .stg(if0));
  pipe_stage_reg #(.CTRL_W(32), .DATA_W(256), .CNT_W(4), .FLUSH_DATA(1))
    u1 (.CLK(CLK), .RESET(RESET), .stg(if1));
  pipe_stage_reg #(.CTRL_W(1), .DATA_W(1), .CNT_W(4), .FLUSH_DATA(0))
    u2 (.CLK(CLK), .RESET(RESET), .stg(if2));

  assign if0.in_valid = d_valid;
  assign if0.in_ctrl  = d_ctrl[10:0];
  assign if0.in_data  = d_data[159:0];
  assign if0.stall    = d_stall;
  assign if0.flush    = d_flush;
  assign if0.cnt_clr  = d_clr;
  assign if1.in_valid = d_valid;
  assign if1.in_ctrl  = d_ctrl;
  assign if1.in_data  = d_data;
  assign if1.stall    = d_stall;
  assign if1.flush    = d_flush;
  assign if1.cnt_clr  = d_clr;
  assign if2.in_valid = d_valid;
  assign if2.in_ctrl  = d_ctrl[0:0];
  assign if2.in_data  = d_data[0:0];
  assign if2.stall    = d_stall;
  assign if2.flush    = d_flush;
  assign if2.cnt_clr  = d_clr;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " u0 valid"},  256'(if0.out_valid),  256'(0));
    chk({tag, " u0 ctrl"},   256'(if0.out_ctrl),   256'(0));
    chk({tag, " u0 data"},   256'(if0.out_data),   256'(0));
    chk({tag, " u1 data"},   256'(if1.out_data),   256'(0));
    chk({tag, " u0 stall"},  256'(if0.stall_cnt),  256'(0));
    chk({tag, " u0 flush"},  256'(if0.flush_cnt),  256'(0));
    chk({tag, " u0 bubble"}, 256'(if0.bubble_cnt), 256'(0));
    chk({tag, " u2 valid"},  256'(if2.out_valid),  256'(0));
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    RESET   = 1'b0;
    d_valid = 1'b1;
    d_ctrl  = 32'h7FF;
    d_data  = '1;
    d_stall = 1'b0;
    d_flush = 1'b0;
    d_clr   = 1'b0;

    // Reset asserted between edges takes effect without a clock
    tick();
    chk("pre u0 ctrl", 256'(if0.out_ctrl), 256'(11'h7FF));
    RESET = 1'b1;
    #1;
    chk_zero("async rst");
    tick();
    chk_zero("held rst");
    RESET = 1'b0;

    // Load and one-cycle latency
    d_ctrl = 32'h155;
    d_data = {8{32'hDEADBEEF}};
    tick();
    chk("ld u0 valid", 256'(if0.out_valid), 256'(1));
    chk("ld u0 ctrl",  256'(if0.out_ctrl),  256'(11'h155));
    chk("ld u0 data",  256'(if0.out_data),  256'({5{32'hDEADBEEF}}));
    chk("ld u1 ctrl",  256'(if1.out_ctrl),  256'(32'h155));
    chk("ld u1 data",  256'(if1.out_data),  {8{32'hDEADBEEF}});
    chk("ld u2 ctrl",  256'(if2.out_ctrl),  256'(1));
    chk("ld u2 data",  256'(if2.out_data),  256'(1));

    // Bubble load: ctrl forced to zero, payload still taken
    d_valid = 1'b0;
    d_ctrl  = 32'h3FF;
    d_data  = 256'h1234;
    tick();
    chk("bub u0 valid",  256'(if0.out_valid),  256'(0));
    chk("bub u0 ctrl",   256'(if0.out_ctrl),   256'(0));
    chk("bub u0 data",   256'(if0.out_data),   256'h1234);
    chk("bub u0 cnt",    256'(if0.bubble_cnt), 256'(1));
    chk("bub u2 ctrl",   256'(if2.out_ctrl),   256'(0));
    chk("bub u2 cnt",    256'(if2.bubble_cnt), 256'(1));

    // Stall for three cycles with changing inputs
    d_valid = 1'b1;
    d_ctrl  = 32'h2AA;
    d_data  = 256'hA5;
    tick();
    chk("stl pre ctrl", 256'(if0.out_ctrl), 256'(11'h2AA));
    d_stall = 1'b1;
    #1;
    chk("stl rdy", 256'(if0.in_ready), 256'(0));
    for (int k = 0; k < 3; k++) begin
      d_ctrl = 32'h100 + 32'(k);
      d_data = 256'(k);
      tick();
      chk("stl u0 ctrl", 256'(if0.out_ctrl), 256'(11'h2AA));
      chk("stl u0 data", 256'(if0.out_data), 256'hA5);
    end
    chk("stl u0 cnt", 256'(if0.stall_cnt), 256'(3));
    chk("stl u2 cnt", 256'(if2.stall_cnt), 256'(3));
    d_stall = 1'b0;
    d_ctrl  = 32'h0F0;
    d_data  = 256'h77;
    #1;
    chk("rel rdy", 256'(if0.in_ready), 256'(1));
    tick();
    chk("rel u0 ctrl", 256'(if0.out_ctrl), 256'(11'h0F0));
    chk("rel u0 data", 256'(if0.out_data), 256'h77);
    chk("rel u0 scnt", 256'(if0.stall_cnt), 256'(3));

    // Flush and stall in the same cycle
    d_flush = 1'b1;
    d_stall = 1'b1;
    #1;
    chk("fs rdy", 256'(if0.in_ready), 256'(1));
    tick();
    chk("fs u0 valid", 256'(if0.out_valid), 256'(0));
    chk("fs u0 ctrl",  256'(if0.out_ctrl),  256'(0));
    chk("fs u0 data",  256'(if0.out_data),  256'h77);
    chk("fs u1 data",  256'(if1.out_data),  256'(0));
    chk("fs u2 data",  256'(if2.out_data),  256'(1));
    chk("fs u0 fcnt",  256'(if0.flush_cnt), 256'(1));
    chk("fs u0 scnt",  256'(if0.stall_cnt), 256'(3));
    chk("fs u1 fcnt",  256'(if1.flush_cnt), 256'(1));
    d_stall = 1'b0;
    tick();
    chk("ff u0 valid", 256'(if0.out_valid), 256'(0));
    chk("ff u0 fcnt",  256'(if0.flush_cnt), 256'(2));

    // Clear, then saturate on a 20-cycle stall
    d_flush = 1'b0;
    d_clr   = 1'b1;
    d_ctrl  = 32'h3C;
    d_data  = 256'h99;
    tick();
    chk("clr u0 fcnt", 256'(if0.flush_cnt),  256'(0));
    chk("clr u0 bcnt", 256'(if0.bubble_cnt), 256'(0));
    chk("clr u0 ctrl", 256'(if0.out_ctrl),   256'(11'h3C));
    d_clr   = 1'b0;
    d_stall = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    chk("sat u0 scnt", 256'(if0.stall_cnt), 256'(20));
    chk("sat u1 scnt", 256'(if1.stall_cnt), 256'(15));
    chk("sat u2 scnt", 256'(if2.stall_cnt), 256'(15));
    d_clr = 1'b1;
    tick();
    chk("satclr u1 scnt", 256'(if1.stall_cnt), 256'(0));
    chk("satclr u0 scnt", 256'(if0.stall_cnt), 256'(0));
    chk("satclr u1 ctrl", 256'(if1.out_ctrl),  256'(32'h3C));
    chk("satclr u1 valid", 256'(if1.out_valid), 256'(1));

    // Reset mid-stall, then flush ignored while in reset
    d_clr = 1'b0;
    tick();
    chk("mid u0 scnt", 256'(if0.stall_cnt), 256'(1));
    RESET = 1'b1;
    #1;
    chk_zero("mid rst");
    d_flush = 1'b1;
    tick();
    chk("rstfl u0 fcnt", 256'(if0.flush_cnt), 256'(0));
    RESET   = 1'b0;
    d_flush = 1'b0;
    d_stall = 1'b0;
    d_ctrl  = 32'h11;
    d_data  = 256'h5;
    tick();
    chk("post u0 valid", 256'(if0.out_valid), 256'(1));
    chk("post u0 ctrl",  256'(if0.out_ctrl),  256'(11'h11));
    chk("post u1 data",  256'(if1.out_data),  256'h5);
    chk("post u0 scnt",  256'(if0.stall_cnt), 256'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
